// File: rtl/axi4_video_stream_checker.sv
// Passive AXI4-Stream video sink that checks frame geometry (tuser = SOF, tlast = EOL)
// and reports per-frame status, counters, the measured size and an XOR checksum.
module axi4_video_stream_checker #(
  parameter int unsigned X_ACTIVE    = 1920,
  parameter int unsigned Y_ACTIVE    = 1080,
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [TDATA_WIDTH-1:0] video_i_tdata,
  input  logic                   video_i_tvalid,
  output logic                   video_i_tready,
  input  logic                   video_i_tlast,
  input  logic                   video_i_tuser,
  output logic                   frame_done_o,
  output logic                   frame_err_o,
  output logic                   line_err_o,
  output logic                   locked_o,
  output logic [31:0]            frame_cnt_o,
  output logic [CNT_WIDTH-1:0]   err_cnt_o,
  output logic [CNT_WIDTH-1:0]   last_width_o,
  output logic [CNT_WIDTH-1:0]   last_height_o,
  output logic [TDATA_WIDTH-1:0] checksum_o
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  localparam logic [CNT_WIDTH-1:0] XA = CNT_WIDTH'(X_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] YA = CNT_WIDTH'(Y_ACTIVE);

  state_e                 state_q, state_d;
  logic                   tready_q;
  logic [CNT_WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [TDATA_WIDTH-1:0] acc_q, acc_d;
  logic                   bad_q, bad_d;
  logic                   frame_done_q, frame_done_d;
  logic                   frame_err_q, frame_err_d;
  logic                   line_err_q, line_err_d;
  logic                   locked_q, locked_d;
  logic [31:0]            frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]   last_w_q, last_w_d, last_h_q, last_h_d;
  logic [TDATA_WIDTH-1:0] cksum_q, cksum_d;

  logic                   beat, sof, sof_early, run, eol, frame_end;
  logic [CNT_WIDTH-1:0]   x_base, y_base, x_inc, y_inc;
  logic [TDATA_WIDTH-1:0] acc_base, acc_new;
  logic                   bad_base;

  // Any SOF restarts the frame from zero, so the per-beat update works on rebased values.
  assign beat      = video_i_tvalid && tready_q;
  assign sof       = beat && video_i_tuser;
  assign sof_early = sof && (state_q == ACTIVE);
  assign run       = beat && ((state_q == ACTIVE) || video_i_tuser);
  assign x_base    = sof ? '0 : x_q;
  assign y_base    = sof ? '0 : y_q;
  assign acc_base  = sof ? '0 : acc_q;
  assign bad_base  = sof ? 1'b0 : bad_q;
  assign x_inc     = (x_base == '1) ? x_base : x_base + 1'b1;
  assign y_inc     = y_base + 1'b1;
  assign acc_new   = acc_base ^ video_i_tdata;
  assign eol       = run && video_i_tlast;
  assign frame_end = eol && (y_inc == YA);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_end)  state_d = IDLE;
    else if (run)   state_d = ACTIVE;
  end

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    acc_d        = acc_q;
    bad_d        = bad_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    line_err_d   = 1'b0;
    locked_d     = locked_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;
    last_w_d     = last_w_q;
    last_h_d     = last_h_q;
    cksum_d      = cksum_q;
    if (sof_early) begin
      frame_done_d = 1'b1;
      frame_err_d  = 1'b1;
      locked_d     = 1'b0;
      err_cnt_d    = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
      last_w_d     = x_q;
      last_h_d     = y_q;
      cksum_d      = acc_q;
    end
    if (run) begin
      acc_d = acc_new;
      bad_d = bad_base;
      x_d   = x_inc;
      y_d   = y_base;
      if (eol) begin
        x_d = '0;
        y_d = y_inc;
        if (x_inc != XA) begin
          line_err_d = 1'b1;
          bad_d      = 1'b1;
        end
      end
      if (frame_end) begin
        frame_done_d = 1'b1;
        last_w_d     = x_inc;
        last_h_d     = y_inc;
        cksum_d      = acc_new;
        if (bad_d) begin
          frame_err_d = 1'b1;
          locked_d    = 1'b0;
          err_cnt_d   = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
        end else begin
          locked_d    = 1'b1;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
        x_d   = '0;
        y_d   = '0;
        acc_d = '0;
        bad_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tready_q     <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      acc_q        <= '0;
      bad_q        <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      line_err_q   <= 1'b0;
      locked_q     <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      last_w_q     <= '0;
      last_h_q     <= '0;
      cksum_q      <= '0;
    end else begin
      tready_q     <= 1'b1;
      x_q          <= x_d;
      y_q          <= y_d;
      acc_q        <= acc_d;
      bad_q        <= bad_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      line_err_q   <= line_err_d;
      locked_q     <= locked_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
      last_w_q     <= last_w_d;
      last_h_q     <= last_h_d;
      cksum_q      <= cksum_d;
    end
  end

  assign video_i_tready = tready_q;
  assign frame_done_o   = frame_done_q;
  assign frame_err_o    = frame_err_q;
  assign line_err_o     = line_err_q;
  assign locked_o       = locked_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign err_cnt_o      = err_cnt_q;
  assign last_width_o   = last_w_q;
  assign last_height_o  = last_h_q;
  assign checksum_o     = cksum_q;

endmodule

// File: tb/tb_axi4_video_stream_checker.sv
// Directed/randomized bench for axi4_video_stream_checker with a frame-level reference model.
module tb_axi4_video_stream_checker;
  localparam int unsigned XA = 4;
  localparam int unsigned YA = 3;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic        tready, frame_done_o, frame_err_o, line_err_o, locked_o;
  logic [31:0] frame_cnt_o, checksum_o;
  logic [15:0] err_cnt_o, last_width_o, last_height_o;

  always #5 clk = ~clk;

  axi4_video_stream_checker #(
    .X_ACTIVE(XA), .Y_ACTIVE(YA), .TDATA_WIDTH(32), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .video_i_tdata(tdata), .video_i_tvalid(tvalid), .video_i_tready(tready),
    .video_i_tlast(tlast), .video_i_tuser(tuser),
    .frame_done_o(frame_done_o), .frame_err_o(frame_err_o), .line_err_o(line_err_o),
    .locked_o(locked_o), .frame_cnt_o(frame_cnt_o), .err_cnt_o(err_cnt_o),
    .last_width_o(last_width_o), .last_height_o(last_height_o), .checksum_o(checksum_o)
  );

  int checks = 0, errors = 0;
  int n_done = 0, n_ferr = 0, n_lerr = 0;

  always @(negedge clk) begin
    if (frame_done_o) n_done++;
    if (frame_err_o)  n_ferr++;
    if (line_err_o)   n_lerr++;
  end

  // Reference model state
  int          e_done = 0, e_ferr = 0, e_lerr = 0;
  logic [31:0] e_fcnt = '0, e_ck = '0, pend_ck = '0;
  int          e_err = 0, e_w = 0, e_h = 0, pend_h = 0;
  logic        e_locked = 1'b0;
  bit          pend = 0, gaps = 0;
  int          ready_drops = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".frame_cnt"}, frame_cnt_o, e_fcnt);
    check({tag, ".err_cnt"}, err_cnt_o, e_err);
    check({tag, ".locked"}, locked_o, e_locked);
    check({tag, ".width"}, last_width_o, e_w);
    check({tag, ".height"}, last_height_o, e_h);
    check({tag, ".checksum"}, checksum_o, e_ck);
  endtask

  task automatic check_pulses(input string tag);
    @(negedge clk);
    check({tag, ".done_pulses"}, n_done, e_done);
    check({tag, ".ferr_pulses"}, n_ferr, e_ferr);
    check({tag, ".lerr_pulses"}, n_lerr, e_lerr);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
    int guard = 0;
    while (gaps && $urandom_range(1, 0) == 0 && guard < 50) begin
      tvalid = 1'b0;
      @(negedge clk);
      if (!tready) ready_drops++;
      guard++;
    end
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    guard = 0;
    while (!tready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("tready_timeout", 0, 1);
    @(negedge clk);
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  // Sends nlines lines of a frame starting with SOF; a frame shorter than YA lines is left open.
  task automatic send_frame(input int l0, input int l1, input int l2, input int nlines,
                            input bit idx, input bit check_first);
    int          lens[3];
    int          beat = 0;
    bit          bad = 0;
    logic [31:0] ck = '0, d;
    lens = '{l0, l1, l2};
    if (pend) begin
      e_done++; e_ferr++; e_err++; e_locked = 1'b0;
      e_h = pend_h; e_w = 0; e_ck = pend_ck; pend = 0;
    end
    for (int ln = 0; ln < nlines; ln++) begin
      for (int p = 0; p < lens[ln]; p++) begin
        d = idx ? 32'(beat) : $urandom;
        send_beat(d, (ln == 0 && p == 0), (p == lens[ln] - 1));
        if (check_first && beat == 0) begin
          check("sof_frame_err", frame_err_o, 1);
          check("sof_frame_done", frame_done_o, 1);
          check_state("sof");
        end
        ck ^= d;
        beat++;
      end
      if (lens[ln] != int'(XA)) begin bad = 1; e_lerr++; end
    end
    if (nlines == int'(YA)) begin
      e_done++; e_w = lens[YA-1]; e_h = YA; e_ck = ck;
      if (bad) begin e_ferr++; e_err++; e_locked = 1'b0; end
      else begin e_fcnt++; e_locked = 1'b1; end
    end else begin
      pend = 1; pend_h = nlines; pend_ck = ck;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_i = 1'b1; tvalid = 1'b0;
    repeat (cycles) @(negedge clk);
    check("rst.tready", tready, 0);
    check("rst.outs", {frame_done_o, frame_err_o, line_err_o, locked_o}, 0);
    check("rst.counts", {frame_cnt_o, err_cnt_o, last_width_o}, 0);
    check("rst.size_ck", {last_height_o, checksum_o}, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("rel.tready", tready, 1);
    e_fcnt = '0; e_err = 0; e_locked = 1'b0; e_w = 0; e_h = 0; e_ck = '0; pend = 0;
  endtask

  initial begin
    do_reset(3);

    // two clean frames with index data
    send_frame(4, 4, 4, 3, 1, 0);
    send_frame(4, 4, 4, 3, 1, 0);
    check_state("clean2");
    check("clean2.ck_const", checksum_o, 0);
    check_pulses("clean2");

    // stray beats before any SOF are ignored
    do_reset(2);
    for (int i = 0; i < 5; i++) send_beat($urandom, 1'b0, 1'(i == 3));
    check_state("idle_beats");
    send_frame(4, 4, 4, 3, 0, 0);
    check_state("after_idle");
    check_pulses("after_idle");

    // over-long line 1
    send_frame(4, 5, 4, 3, 0, 0);
    check_state("long_line");
    check_pulses("long_line");

    // tuser and tlast together: 1-pixel line 0
    send_frame(1, 4, 4, 3, 0, 0);
    check_state("sof_eol");
    check_pulses("sof_eol");

    // premature SOF after two full lines, then a clean frame relocks
    send_frame(4, 4, 4, 2, 0, 0);
    send_frame(4, 4, 4, 3, 0, 1);
    check_state("relock");
    check_pulses("relock");

    // 50% tvalid duty over three clean frames
    gaps = 1;
    for (int f = 0; f < 3; f++) send_frame(4, 4, 4, 3, 0, 0);
    gaps = 0;
    check_state("gaps");
    check_pulses("gaps");
    check("gaps.tready_drops", ready_drops, 0);

    // reset in the middle of line 1
    send_frame(4, 4, 4, 1, 0, 0);
    send_beat($urandom, 1'b0, 1'b0);
    send_beat($urandom, 1'b0, 1'b0);
    do_reset(1);
    send_frame(4, 4, 4, 3, 0, 0);
    check_state("post_rst");
    check("post_rst.fcnt_one", frame_cnt_o, 1);
    check_pulses("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi4_video_stream_checker.md
Name: axi4_video_stream_checker

Overview:
Passive sink/monitor placed directly downstream of the AXI4-Stream video pattern generator. It consumes a 32-bit video stream that uses tuser as start-of-frame (SOF) and tlast as end-of-line (EOL), and checks the frame geometry against the configured active size. It reports per-frame status, error and frame counters, the measured frame size and a per-frame XOR checksum. It is used as the bench and on-chip consumer for generator bring-up.

Parameters:
X_ACTIVE, 1920, expected pixels (beats) per line
Y_ACTIVE, 1080, expected lines per frame
TDATA_WIDTH, 32, stream data width
CNT_WIDTH, 16, width of the x/y counters, the measured-size outputs and err_cnt_o

Ports:
clk_i  in  1  single clock
rst_i  in  1  reset, synchronous, active-high
video_i_tdata  in  TDATA_WIDTH  pixel data
video_i_tvalid  in  1  beat valid
video_i_tready  out  1  sink ready (registered)
video_i_tlast  in  1  end of line
video_i_tuser  in  1  start of frame (first pixel of frame)
frame_done_o  out  1  1-cycle pulse at each frame end, good or bad
frame_err_o  out  1  1-cycle pulse when a frame ends bad or is cut short by SOF
line_err_o  out  1  1-cycle pulse when a line length is not equal to X_ACTIVE
locked_o  out  1  high after an error-free frame; cleared by any frame error
frame_cnt_o  out  32  count of good frames, wraps around
err_cnt_o  out  CNT_WIDTH  count of bad frames, saturating
last_width_o  out  CNT_WIDTH  pixel count of the last line of the last ended frame
last_height_o  out  CNT_WIDTH  line count of the last ended frame
checksum_o  out  TDATA_WIDTH  XOR of all tdata beats of the last ended frame

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: every output is 0, including tready. The FSM goes to IDLE and all counters and the accumulator clear.
- tready: registered copy of !rst_i. It is 0 during reset and 1 from the first cycle after rst_i is released. The block never back-pressures after that.
- Beat: a beat is accepted on a cycle where tvalid and tready are both 1. Inputs are ignored on all other cycles, so tvalid gaps have no effect.
- Latency: all pulses and latched outputs are registered. They update 1 cycle after the accepting beat.
- FSM state IDLE:
  - Accepted beats without tuser are discarded, with no flags raised.
  - A beat with tuser moves the FSM to ACTIVE and is processed as pixel 0 of line 0.
- FSM state ACTIVE:
  - Each beat: x_cnt increments (saturates at the all-ones value), and acc is XORed with tdata.
  - Beat with tlast: line length = x_cnt including this beat. If the length is not X_ACTIVE, pulse line_err_o and set the frame's bad flag. Then y_cnt increments and x_cnt clears.
  - When y_cnt reaches Y_ACTIVE (end of the last line), the frame ends:
    - last_width_o and last_height_o are latched, checksum_o is latched, and frame_done_o pulses.
    - Frame not bad: frame_cnt_o increments and locked_o is set to 1.
    - Frame bad: frame_err_o pulses, err_cnt_o increments and locked_o is set to 0.
    - The FSM returns to IDLE. The acc, x, y and bad-flag registers clear.
- Premature SOF (tuser while ACTIVE and the beat is not pixel 0 of the frame):
  - The old frame ends bad: frame_done_o and frame_err_o pulse, err_cnt_o increments and locked_o is set to 0.
  - last_height_o = lines completed so far. last_width_o = x_cnt of the partial line. checksum_o = acc before this beat.
  - The same beat starts a new frame as pixel 0 (acc = tdata). The FSM stays in ACTIVE.
- tuser and tlast on the same beat: SOF handling is applied first, then EOL handling. The result is a 1-pixel line 0.
- Missing tlast: pixels beyond X_ACTIVE keep counting. The line is flagged only at its tlast, or at a premature SOF.
- Reset mid-frame: everything is discarded. The block waits in IDLE for the next SOF.

Test Plan:
- Params X_ACTIVE=4, Y_ACTIVE=3. Send two clean frames with tdata = beat index 0..11 per frame -> frame_done_o pulses 2 times, frame_cnt_o=2, err_cnt_o=0, locked_o=1, last_width_o=4, last_height_o=3, checksum_o = XOR(0..11) = 0x0.
- Send 5 beats with no tuser after reset, then one clean frame -> the 5 beats are ignored, frame_cnt_o=1, and no line_err_o or frame_err_o pulses.
- Make line 1 five beats long (tlast on beat 5) -> line_err_o pulses once, frame end gives frame_err_o plus frame_done_o, err_cnt_o=1, frame_cnt_o unchanged, locked_o=0.
- Assert tuser again after 2 full lines -> frame_err_o pulses, last_height_o=2, last_width_o=0, err_cnt_o+1. The following frame completes clean and locked_o returns to 1.
- Randomise tvalid at 50% duty over 3 clean frames -> results are identical to the gap-free run, and tready stays 1 throughout.
- Assert rst_i for 1 cycle in mid-line 1 -> all outputs are 0 and tready is 0 during reset. The partial frame is not counted, and the next SOF frame counts normally (frame_cnt_o=1).
